dds_phase_accumulator: RTL
==========================

Name: dds_phase_accumulator

Overview:
Downstream consumer of the preescaller's slow_clock output. Treats slow_clock as a synchronous tick: on each rising edge it advances a DDS phase accumulator by the active tuning word. It emits a quarter-wave LUT address plus a negate flag for the sine ROM stage. Frequency changes arrive through a valid/ready handshake and take effect only at accumulator wrap-around, so the output stays phase-continuous.

Parameters:
ACC_WIDTH, 32, accumulator and tuning word width
ADDR_WIDTH, 8, quarter-wave LUT address width (must be <= ACC_WIDTH-2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  step qualifier; when low, ticks are ignored
slow_clock  input  1  tick from preescaller, sampled on clock
tw_in  input  ACC_WIDTH  new tuning word
tw_valid  input  1  tw_in offered
tw_ready  output  1  pending slot empty; transfer when tw_valid & tw_ready
phase  output  ACC_WIDTH  accumulator value
lut_addr  output  ADDR_WIDTH  folded quarter-wave ROM address
negate  output  1  second half-wave; downstream negates ROM output
sample_valid  output  1  one-cycle pulse, phase/lut_addr/negate updated
cycle_count  output  16  accumulator wrap count, modulo 2^16

Behaviour:
- Reset: the block holds this state while reset is high and for the first cycle after it drops.
  - acc=0, tw_active=0, pending empty, tw_ready=1.
  - phase=0, lut_addr=0, negate=0, sample_valid=0, cycle_count=0.
  - tick_q=1, so a slow_clock already high at reset release is not counted as an edge.
- Edge detect: tick_q <= slow_clock every cycle. step = enable & slow_clock & ~tick_q.
- Step (detected in cycle N):
  - sum = acc + tw_active, ACC_WIDTH+1 bits. carry = sum[ACC_WIDTH].
  - acc <= sum modulo 2^ACC_WIDTH. phase, lut_addr and negate are registered from the new acc and are visible at N+1.
  - sample_valid = 1 in N+1 only.
- Folding: q = acc_next[ACC_WIDTH-1:ACC_WIDTH-2] and a = acc_next[ACC_WIDTH-3 -: ADDR_WIDTH].
  - lut_addr = q[0] ? ~a : a.
  - negate = q[1].
- Wrap: when carry is set, cycle_count increments modulo 2^16; 0xFFFF wraps to 0.
- Handshake:
  - On tw_valid & tw_ready: tw_pending <= tw_in, pending full, tw_ready = 0 from the next cycle.
  - Pending is applied (tw_active <= tw_pending, pending cleared) in either of two cases:
    - (a) on a step with carry; the new word is used from the following step.
    - (b) on any cycle where tw_active == 0, whether or not a step occurs, including while enable is low.
  - tw_ready returns to 1 the cycle after the apply.
  - A step in the same cycle as an idle apply (b) still uses the old tw_active = 0.
- enable low: acc, outputs and cycle_count hold, sample_valid = 0. The handshake and idle apply still operate.
- slow_clock held high: counts once only.
- Reset mid-operation: an in-flight pending word is discarded. All registers return to reset values on the next clock edge.

Test Plan:
- Basic stepping:
  - Stimulus: reset; load tw=0x40000000 (applied idle); 4 slow_clock pulses.
  - Required: phase 0x40000000, 0x80000000, 0xC0000000, 0x00000000.
  - Required: lut_addr 0xFF, 0x00, 0xFF, 0x00; negate 0, 1, 1, 0; cycle_count 0, 0, 0, 1; one sample_valid per pulse at edge+1.
- Held tick: slow_clock held high 10 cycles, then low -> exactly one step; one sample_valid.
- Retune:
  - Stimulus: tw_active=0x40000000, phase=0x40000000; offer tw=0x20000000.
  - Required: tw_ready drops; next steps give 0x80000000, 0xC0000000, 0x00000000 (apply at wrap); tw_ready back to 1.
  - Required: next step gives 0x20000000.
- Enable low: enable=0 with 5 pulses -> phase unchanged, sample_valid stays 0; a handshake offered meanwhile still completes.
- Reset mid-operation: reset asserted with phase=0xC0000000, pending full, slow_clock high at release -> all outputs 0, tw_ready=1; no step until a fresh rising edge.
- Counter wrap: tw=0x80000000, 131072 pulses -> cycle_count goes 0xFFFF -> 0x0000 on the final pulse; phase=0.

Source files
------------

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator stepped by rising edges of an external slow tick.
// Emits a folded quarter-wave ROM address plus negate flag; retunes only at wrap.
module dds_phase_accumulator #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  slow_clock,
  input  logic [ACC_WIDTH-1:0]  tw_in,
  input  logic                  tw_valid,
  output logic                  tw_ready,
  output logic [ACC_WIDTH-1:0]  phase,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  output logic                  negate,
  output logic                  sample_valid,
  output logic [15:0]           cycle_count
);

  logic                  tick_r;
  logic [ACC_WIDTH-1:0]  tw_active_r;
  logic [ACC_WIDTH-1:0]  tw_pending_r;

  logic                  step_s;
  logic [ACC_WIDTH:0]    sum_s;
  logic                  carry_s;
  logic [ACC_WIDTH-1:0]  acc_next_s;
  logic [1:0]            quad_s;
  logic [ADDR_WIDTH-1:0] fine_s;
  logic                  accept_s;
  logic                  apply_s;

  // Odd quadrants run the quarter-wave table backwards.
  function automatic logic [ADDR_WIDTH-1:0] fold_addr(input logic [1:0] q,
                                                      input logic [ADDR_WIDTH-1:0] a);
    if (q[0]) begin
      return ~a;
    end else begin
      return a;
    end
  endfunction

  // Tick edge detect, accumulator sum, folding and handshake decisions.
  always_comb begin
    step_s     = enable & slow_clock & ~tick_r;
    sum_s      = {1'b0, phase} + {1'b0, tw_active_r};
    carry_s    = sum_s[ACC_WIDTH];
    acc_next_s = sum_s[ACC_WIDTH-1:0];
    quad_s     = acc_next_s[ACC_WIDTH-1 -: 2];
    fine_s     = acc_next_s[ACC_WIDTH-3 -: ADDR_WIDTH];
    accept_s   = tw_valid & tw_ready;
    // The pending slot is full exactly when tw_ready is low.
    apply_s    = ~tw_ready & ((step_s & carry_s) | (tw_active_r == {ACC_WIDTH{1'b0}}));
  end

  // State and registered outputs; phase doubles as the accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_r       <= 1'b1;
      tw_active_r  <= {ACC_WIDTH{1'b0}};
      tw_pending_r <= {ACC_WIDTH{1'b0}};
      tw_ready     <= 1'b1;
      phase        <= {ACC_WIDTH{1'b0}};
      lut_addr     <= {ADDR_WIDTH{1'b0}};
      negate       <= 1'b0;
      sample_valid <= 1'b0;
      cycle_count  <= 16'd0;
    end else begin
      tick_r       <= slow_clock;
      sample_valid <= step_s;
      if (step_s) begin
        phase    <= acc_next_s;
        lut_addr <= fold_addr(quad_s, fine_s);
        negate   <= quad_s[1];
        if (carry_s) begin
          cycle_count <= cycle_count + 16'd1;
        end
      end
      if (apply_s) begin
        tw_active_r <= tw_pending_r;
        tw_ready    <= 1'b1;
      end else if (accept_s) begin
        tw_pending_r <= tw_in;
        tw_ready     <= 1'b0;
      end
    end
  end

endmodule
